snes_bus_sequencer: RTL
=======================

// Module: snes_bus_sequencer
// PURPOSE
//  Parametrised SNES CPU bus-cycle generator. Executes queued read/write/idle
//  commands as cycle-accurate SNES bus cycles (ADDR, /RD, /WR, CPU_CLK, data).
//  Supports per-command speed (fast/slow/xslow), bursts with address
//  increment, and returns captured read data. Drives main in board-level
//  benches and the FPGA self-test path.
// PARAMETERS
//  ADDR_W     24  SNES address width.
//  DATA_W     8   SNES data width.
//  T_FAST     6   CLK ticks per fast bus cycle (even, >=4).
//  T_SLOW     8   CLK ticks per slow bus cycle (even, >=4).
//  T_XSLOW    12  CLK ticks per xslow bus cycle (even, >=4).
//  BANK_WRAP  1   1: burst increment wraps within addr[15:0]. 0: full-width wrap.
// PORTS
//  CLK           in   1       Sequencer clock.
//  RST           in   1       Reset, asynchronous, active-high.
//  cmd_valid     in   1       Command offered.
//  cmd_ready     out  1       Command accepted when valid&ready at rising CLK.
//  cmd_op        in   2       0 read, 1 write, 2 idle, 3 reserved (= idle).
//  cmd_speed     in   2       0 fast, 1 slow, 2 xslow, 3 reserved (= xslow).
//  cmd_addr      in   ADDR_W  Start address.
//  cmd_wdata     in   DATA_W  Write data, same value for all burst beats.
//  cmd_len       in   8       Beats minus one (0 -> 1 beat, 255 -> 256 beats).
//  SNES_ADDR     out  ADDR_W  Bus address.
//  SNES_READ     out  1       /RD, active low.
//  SNES_WRITE    out  1       /WR, active low.
//  SNES_CPU_CLK  out  1       CPU clock phase.
//  SNES_DATA_OUT out  DATA_W  Write data.
//  SNES_DATA_OE  out  1       1 = sequencer drives the data bus.
//  SNES_DATA_IN  in   DATA_W  Bus read data.
//  rd_valid      out  1       One-cycle pulse, read beat captured. No backpressure.
//  rd_data       out  DATA_W  Captured data.
//  rd_addr       out  ADDR_W  Address of captured beat.
//  busy          out  1       1 while any command is executing.
// BEHAVIOUR
//  Reset (async): SNES_ADDR=0, SNES_READ=1, SNES_WRITE=1, SNES_CPU_CLK=0,
//   SNES_DATA_OUT=0, SNES_DATA_OE=0, rd_valid=0, rd_data=0, rd_addr=0, busy=0.
//   State=IDLE. All outputs registered. Reset mid-beat aborts at once; the
//   partial command is discarded.
//  FSM: IDLE -> LOW (phases 0..N/2-1) -> HIGH (phases N/2..N-1) -> LOW (next
//   beat) | IDLE. N = ticks for the latched speed.
//  cmd_ready=1 in IDLE, and on the last HIGH phase of the final beat. This
//   gives back-to-back commands with no gap: phase 0 of the new command falls
//   on the next CLK.
//  Accept latches op/speed/addr/wdata/len. Output update lags by 1 CLK.
//  LOW: CPU_CLK=0, addr valid, READ=WRITE=1, DATA_OE=0.
//  HIGH: CPU_CLK=1. read -> READ=0. write -> WRITE=0, DATA_OE=1,
//   DATA_OUT=wdata. idle -> strobes stay 1 (CPU_CLK still toggles).
//  Read capture: SNES_DATA_IN sampled on the last HIGH phase. rd_valid pulses
//   on the following CLK, with the beat's address.
//  Strobes return to 1 and DATA_OE to 0 on the first LOW phase of the next
//   beat, or in IDLE. There are no overlapping strobes.
//  Burst: beat k uses addr+k. BANK_WRAP=1 -> {addr[23:16], addr[15:0]+k mod
//   2^16}. Otherwise mod 2^ADDR_W.
//  Speed fixed for whole command. busy = (state != IDLE).
// STRUCTURE
//  snes_bus_defs.vh: op/speed encodings, FSM state codes.
//  Sub-module snes_bus_timer: phase counter loaded with N, outputs
//   half/last-phase flags.
// TESTING
//  Reset, then idle 10 CLK -> READ=WRITE=1, CPU_CLK=0, DATA_OE=0,
//   cmd_ready=1, busy=0.
//  Write 0x208000=0x1F fast, len 0 -> WRITE low for exactly 3 CLK,
//   DATA_OUT=0x1F with OE=1, then IDLE.
//  Read 0x00FFFE xslow, len 3, BANK_WRAP=1, bus model returns addr[7:0] ->
//   addresses FFFE, FFFF, 0000, 0001 in bank 00. rd_data FE, FF, 00, 01.
//   Four rd_valid pulses.
//  Two read commands with cmd_valid held -> second beat phase 0 directly
//   follows first's last phase. Period stays 6 CLK (fast).
//  Assert RST during write HIGH phase -> WRITE=1, OE=0 same cycle. After
//   release, no further beats and no rd_valid.
//  Idle op slow len 4 -> 5 CPU_CLK periods of 8 CLK, strobes never low.

Source files
------------

// File: rtl/snes_bus_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// snes_bus_sequencer_pkg
// Shared encodings for the SNES bus-cycle sequencer: command op codes, speed
// codes, FSM state codes and the speed -> ticks-per-bus-cycle lookup.
// No ports (package).
// -----------------------------------------------------------------------------
package snes_bus_sequencer_pkg;

    // Width of the phase counter; large enough for any sane tick count.
    localparam int PHASE_W = 8;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_IDLE  = 2'd2,
        OP_RSVD  = 2'd3   // behaves as idle
    } bus_op_e;

    typedef enum logic [1:0] {
        SPD_FAST  = 2'd0,
        SPD_SLOW  = 2'd1,
        SPD_XSLOW = 2'd2,
        SPD_RSVD  = 2'd3  // behaves as xslow
    } bus_speed_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } seq_state_e;

    // Clock ticks per bus cycle for a given speed code.
    function automatic logic [PHASE_W-1:0] ticks_for_speed(
        input bus_speed_e speed,
        input int         t_fast,
        input int         t_slow,
        input int         t_xslow
    );
        case (speed)
            SPD_FAST: return PHASE_W'(t_fast);
            SPD_SLOW: return PHASE_W'(t_slow);
            default:  return PHASE_W'(t_xslow);
        endcase
    endfunction

endpackage

// File: rtl/snes_bus_sequencer_if.sv
// -----------------------------------------------------------------------------
// snes_bus_sequencer_if
// Command, SNES bus and read-return signals of the sequencer.
//   master : the sequencer (accepts commands, drives the SNES bus, returns reads)
//   slave  : the host / bus model side
// cmd_*    : command offer (valid/ready handshake), op, speed, addr, wdata, len
// snes_*   : address, /RD, /WR, CPU clock, write data + output enable, read data
// rd_*     : captured read beat (one-cycle pulse, no backpressure)
// busy     : a command is executing
// -----------------------------------------------------------------------------
interface snes_bus_sequencer_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [1:0]        cmd_speed;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [7:0]        cmd_len;

    logic [ADDR_W-1:0] snes_addr;
    logic              snes_read;
    logic              snes_write;
    logic              snes_cpu_clk;
    logic [DATA_W-1:0] snes_data_out;
    logic              snes_data_oe;
    logic [DATA_W-1:0] snes_data_in;

    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              busy;

    modport master (
        input  cmd_valid, cmd_op, cmd_speed, cmd_addr, cmd_wdata, cmd_len,
        input  snes_data_in,
        output cmd_ready,
        output snes_addr, snes_read, snes_write, snes_cpu_clk,
        output snes_data_out, snes_data_oe,
        output rd_valid, rd_data, rd_addr, busy
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_speed, cmd_addr, cmd_wdata, cmd_len,
        output snes_data_in,
        input  cmd_ready,
        input  snes_addr, snes_read, snes_write, snes_cpu_clk,
        input  snes_data_out, snes_data_oe,
        input  rd_valid, rd_data, rd_addr, busy
    );
endinterface

// File: rtl/snes_bus_sequencer_timer.sv
// -----------------------------------------------------------------------------
// snes_bus_sequencer_timer
// Phase counter for one bus cycle. start loads the tick count N and restarts
// at phase 0; while run is high the phase advances and wraps after N-1.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : restart at phase 0 with ticks (new command)
//   run        : advance phase
//   ticks      : N for the command being started
//   half_last  : current phase is N/2-1 (last LOW phase)
//   last       : current phase is N-1 (last HIGH phase)
// -----------------------------------------------------------------------------
module snes_bus_sequencer_timer
    import snes_bus_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               run,
    input  logic [PHASE_W-1:0] ticks,
    output logic               half_last,
    output logic               last
);
    logic [PHASE_W-1:0] phase_reg;
    logic [PHASE_W-1:0] ticks_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_reg <= '0;
            ticks_reg <= '0;
        end else if (start) begin
            phase_reg <= '0;
            ticks_reg <= ticks;
        end else if (run) begin
            phase_reg <= last ? '0 : phase_reg + 1'b1;
        end
    end

    assign half_last = (phase_reg == (ticks_reg >> 1) - 1'b1);
    assign last      = (phase_reg == ticks_reg - 1'b1);
endmodule

// File: rtl/snes_bus_sequencer.sv
// -----------------------------------------------------------------------------
// snes_bus_sequencer
// Executes queued read/write/idle commands as SNES CPU bus cycles. Each beat is
// N ticks: N/2 LOW phases (CPU_CLK=0, strobes released) then N/2 HIGH phases
// (CPU_CLK=1, /RD or /WR asserted for the op). Bursts step the address per
// beat; read data is sampled on the last HIGH phase and returned on rd_*.
//   clk, rst : clock, asynchronous active-high reset (aborts any command)
//   bus      : master side of snes_bus_sequencer_if (command in, SNES bus out,
//              read return out, busy)
// All bus and read-return outputs are registered from the current state, so
// they trail the FSM by one clock.
// -----------------------------------------------------------------------------
module snes_bus_sequencer
    import snes_bus_sequencer_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 8,
    parameter int T_FAST    = 6,
    parameter int T_SLOW    = 8,
    parameter int T_XSLOW   = 12,
    parameter int BANK_WRAP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    snes_bus_sequencer_if.master bus
);
    seq_state_e        state_reg, state_next;
    bus_op_e           op_reg;
    logic [ADDR_W-1:0] addr_reg;      // address of the current beat
    logic [ADDR_W-1:0] addr_inc;
    logic [DATA_W-1:0] wdata_reg;
    logic [7:0]        len_reg;
    logic [7:0]        beat_reg;

    logic cmd_ready, accept, final_beat, beat_done;
    logic timer_half_last, timer_last;

    logic [ADDR_W-1:0] snes_addr_reg, snes_addr_next;
    logic              snes_read_reg, snes_read_next;
    logic              snes_write_reg, snes_write_next;
    logic              snes_cpu_clk_reg, snes_cpu_clk_next;
    logic [DATA_W-1:0] snes_data_out_reg, snes_data_out_next;
    logic              snes_data_oe_reg, snes_data_oe_next;
    logic              rd_valid_reg, rd_valid_next;
    logic [DATA_W-1:0] rd_data_reg, rd_data_next;
    logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;

    assign final_beat = (beat_reg == len_reg);
    assign beat_done  = (state_reg == ST_HIGH) && timer_last;
    // Ready on the very last phase too, so a queued command starts its phase 0
    // on the next clock with no gap.
    assign cmd_ready  = (state_reg == ST_IDLE) || (beat_done && final_beat);
    assign accept     = bus.cmd_valid && cmd_ready;

    snes_bus_sequencer_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .start     (accept),
        .run       (state_reg != ST_IDLE),
        .ticks     (ticks_for_speed(bus_speed_e'(bus.cmd_speed), T_FAST, T_SLOW, T_XSLOW)),
        .half_last (timer_half_last),
        .last      (timer_last)
    );

    // Burst address step: either stay inside the bank or wrap the full width.
    generate
        if (BANK_WRAP != 0 && ADDR_W > 16) begin : g_bank_wrap
            assign addr_inc = {addr_reg[ADDR_W-1:16], addr_reg[15:0] + 16'd1};
        end else begin : g_full_wrap
            assign addr_inc = addr_reg + 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            op_reg    <= OP_IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            len_reg   <= '0;
            beat_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg    <= bus_op_e'(bus.cmd_op);
                addr_reg  <= bus.cmd_addr;
                wdata_reg <= bus.cmd_wdata;
                len_reg   <= bus.cmd_len;
                beat_reg  <= '0;
            end else if (beat_done) begin
                beat_reg  <= beat_reg + 1'b1;
                addr_reg  <= addr_inc;
            end
        end
    end

    always_comb begin
        state_next         = state_reg;
        snes_addr_next     = snes_addr_reg;
        snes_read_next     = 1'b1;
        snes_write_next    = 1'b1;
        snes_cpu_clk_next  = 1'b0;
        snes_data_out_next = snes_data_out_reg;
        snes_data_oe_next  = 1'b0;
        rd_valid_next      = 1'b0;
        rd_data_next       = rd_data_reg;
        rd_addr_next       = rd_addr_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = ST_LOW;
            end
            ST_LOW: begin
                snes_addr_next = addr_reg;
                if (timer_half_last) state_next = ST_HIGH;
            end
            ST_HIGH: begin
                snes_addr_next    = addr_reg;
                snes_cpu_clk_next = 1'b1;
                case (op_reg)
                    OP_READ: begin
                        snes_read_next = 1'b0;
                        if (timer_last) begin
                            rd_valid_next = 1'b1;
                            rd_data_next  = bus.snes_data_in;
                            rd_addr_next  = addr_reg;
                        end
                    end
                    OP_WRITE: begin
                        snes_write_next    = 1'b0;
                        snes_data_oe_next  = 1'b1;
                        snes_data_out_next = wdata_reg;
                    end
                    default: ;  // idle: clock toggles, strobes stay released
                endcase
                if (timer_last)
                    state_next = (final_beat && !accept) ? ST_IDLE : ST_LOW;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snes_addr_reg     <= '0;
            snes_read_reg     <= 1'b1;
            snes_write_reg    <= 1'b1;
            snes_cpu_clk_reg  <= 1'b0;
            snes_data_out_reg <= '0;
            snes_data_oe_reg  <= 1'b0;
            rd_valid_reg      <= 1'b0;
            rd_data_reg       <= '0;
            rd_addr_reg       <= '0;
        end else begin
            snes_addr_reg     <= snes_addr_next;
            snes_read_reg     <= snes_read_next;
            snes_write_reg    <= snes_write_next;
            snes_cpu_clk_reg  <= snes_cpu_clk_next;
            snes_data_out_reg <= snes_data_out_next;
            snes_data_oe_reg  <= snes_data_oe_next;
            rd_valid_reg      <= rd_valid_next;
            rd_data_reg       <= rd_data_next;
            rd_addr_reg       <= rd_addr_next;
        end
    end

    assign bus.cmd_ready     = cmd_ready;
    assign bus.busy          = (state_reg != ST_IDLE);
    assign bus.snes_addr     = snes_addr_reg;
    assign bus.snes_read     = snes_read_reg;
    assign bus.snes_write    = snes_write_reg;
    assign bus.snes_cpu_clk  = snes_cpu_clk_reg;
    assign bus.snes_data_out = snes_data_out_reg;
    assign bus.snes_data_oe  = snes_data_oe_reg;
    assign bus.rd_valid      = rd_valid_reg;
    assign bus.rd_data       = rd_data_reg;
    assign bus.rd_addr       = rd_addr_reg;
endmodule
